// File: rtl/fsmc_read_arbiter.sv
// fsmc_read_arbiter: round-robin producer arbiter feeding a read FIFO exposed on FSMC data/status slots.
// Optional macro FSMC_ARB_SRC_TAG_EN stores each entry's source index and reports the head's index in stat_word[13:8].
module fsmc_read_arbiter #(
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_SOURCES = 4,
    parameter int FIFO_DEPTH  = 16,
    parameter int IRQ_LEVEL   = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_SOURCES-1:0]        src_valid,
    input  logic [DATA_WIDTH-1:0]         src_data [NUM_SOURCES],
    output logic [NUM_SOURCES-1:0]        src_ready,
    input  logic                          bus_cs_data,
    input  logic                          bus_cs_stat,
    input  logic                          bus_state,
    input  logic [DATA_WIDTH-1:0]         bus_wdata,
    output logic [DATA_WIDTH-1:0]         data_word,
    output logic [DATA_WIDTH-1:0]         stat_word,
    output logic                          mcu_irq,
    output logic [$clog2(FIFO_DEPTH):0]   level
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int SW = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;

    logic                  cs_data_q, cs_stat_q;
    logic                  data_rd, stat_rd, flush;
    logic [PW-1:0]         rd_ptr, wr_ptr, rd_next;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [SW-1:0]         rr_ptr, gnt_idx;
    logic [NUM_SOURCES-1:0] gnt;
    logic                  gnt_any, can_push, push, pop, underflow;
    logic [LW-1:0]         lvl_after_pop;
    logic [DATA_WIDTH-1:0] head_next;
    logic [5:0]            head_tag;
    logic                  unused_wdata;

    assign unused_wdata = ^bus_wdata[DATA_WIDTH-1:1];

    // A pending flush or a full FIFO blocks every grant this cycle.
    assign can_push = !reset && (level < LW'(FIFO_DEPTH)) && !flush;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int k = 0; k < NUM_SOURCES; k++) begin
            int s;
            s = int'(rr_ptr) + k;
            if (s >= NUM_SOURCES) s = s - NUM_SOURCES;
            if (can_push && !gnt_any && src_valid[SW'(s)]) begin
                gnt[SW'(s)] = 1'b1;
                gnt_idx     = SW'(s);
                gnt_any     = 1'b1;
            end
        end
    end

    assign src_ready     = gnt;
    assign push          = gnt_any;
    assign pop           = data_rd && (level != '0) && !flush;
    assign rd_next       = rd_ptr + PW'(pop);
    assign lvl_after_pop = level - LW'(pop);
    // Head after this cycle: next stored entry, else the word being pushed into an empty FIFO.
    assign head_next     = flush ? '0 : (lvl_after_pop != '0) ? mem[rd_next] : push ? src_data[gnt_idx] : '0;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= src_data[gnt_idx];
    end

`ifdef FSMC_ARB_SRC_TAG_EN
    logic [SW-1:0] tag_mem [FIFO_DEPTH];
    logic [SW-1:0] tag_q, tag_next;

    assign tag_next = flush ? '0 : (lvl_after_pop != '0) ? tag_mem[rd_next] : push ? gnt_idx : '0;
    assign head_tag = 6'(tag_q);

    always_ff @(posedge clk) begin
        if (push) tag_mem[wr_ptr] <= gnt_idx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) tag_q <= '0;
        else       tag_q <= tag_next;
    end
`else
    assign head_tag = '0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_data_q <= 1'b0;
            cs_stat_q <= 1'b0;
            data_rd   <= 1'b0;
            stat_rd   <= 1'b0;
            flush     <= 1'b0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            level     <= '0;
            rr_ptr    <= '0;
            underflow <= 1'b0;
            data_word <= '0;
            mcu_irq   <= 1'b0;
            stat_word <= '0;
        end else begin
            cs_data_q <= bus_cs_data;
            cs_stat_q <= bus_cs_stat;
            // Chip-select falling edges are registered; the FIFO acts on them one clock later.
            data_rd   <= cs_data_q && !bus_cs_data && bus_state;
            stat_rd   <= cs_stat_q && !bus_cs_stat && bus_state;
            flush     <= cs_stat_q && !bus_cs_stat && !bus_state && bus_wdata[0];
            rd_ptr    <= flush ? '0 : rd_next;
            wr_ptr    <= flush ? '0 : wr_ptr + PW'(push);
            level     <= flush ? '0 : lvl_after_pop + LW'(push);
            rr_ptr    <= !push ? rr_ptr : (gnt_idx == SW'(NUM_SOURCES - 1)) ? '0 : gnt_idx + SW'(1);
            underflow <= (data_rd && level == '0) ? 1'b1 : stat_rd ? 1'b0 : underflow;
            data_word <= head_next;
            mcu_irq   <= level >= LW'(IRQ_LEVEL);
            stat_word <= {underflow, level >= LW'(IRQ_LEVEL), head_tag, 8'(level)};
        end
    end
endmodule

// File: tb/tb_fsmc_read_arbiter.sv
// tb_fsmc_read_arbiter: directed and randomized bench with a queue-based reference model of the read arbiter.
module tb_fsmc_read_arbiter;
    localparam int N = 4, D = 16, IRQ = 8;

    logic        clk = 0, reset = 0;
    logic [N-1:0] src_valid = '0, src_ready;
    logic [15:0] src_data [N];
    logic        bus_cs_data = 0, bus_cs_stat = 0, bus_state = 0;
    logic [15:0] bus_wdata = '0, data_word, stat_word;
    logic        mcu_irq;
    logic [4:0]  level;
    int          checks = 0, errors = 0;
    bit          chk_on = 0;

    fsmc_read_arbiter #(.DATA_WIDTH(16), .NUM_SOURCES(N), .FIFO_DEPTH(D), .IRQ_LEVEL(IRQ)) dut (
        .clk(clk), .reset(reset), .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
        .bus_cs_data(bus_cs_data), .bus_cs_stat(bus_cs_stat), .bus_state(bus_state), .bus_wdata(bus_wdata),
        .data_word(data_word), .stat_word(stat_word), .mcu_irq(mcu_irq), .level(level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO as a queue, pending bus events applied one clock after detection.
    int q[$], qt[$];
    int m_rr = 0;
    bit m_unf = 0, pcs_d = 0, pcs_s = 0, ev_d = 0, ev_s = 0, ev_f = 0, e_irq = 0;
    logic [15:0] e_stat = '0;

    function automatic int grant_idx();
        if (reset || ev_f || q.size() >= D) return -1;
        for (int k = 0; k < N; k++)
            if (src_valid[(m_rr + k) % N]) return (m_rr + k) % N;
        return -1;
    endfunction

    function automatic logic [15:0] head();
        return q.size() != 0 ? 16'(q[0]) : 16'h0;
    endfunction

    function automatic int htag();
`ifdef FSMC_ARB_SRC_TAG_EN
        return q.size() != 0 ? qt[0] : 0;
`else
        return 0;
`endif
    endfunction

    task automatic model_step();
        int g;
        if (reset) begin
            q.delete(); qt.delete();
            m_rr = 0; m_unf = 0; pcs_d = 0; pcs_s = 0;
            ev_d = 0; ev_s = 0; ev_f = 0; e_irq = 0; e_stat = '0;
            return;
        end
        g = grant_idx();
        e_stat = {m_unf, q.size() >= IRQ, 6'(htag()), 8'(q.size())};
        e_irq = q.size() >= IRQ;
        if (ev_d && q.size() == 0) m_unf = 1;
        else if (ev_s) m_unf = 0;
        if (ev_f) begin
            q.delete(); qt.delete();
        end else begin
            if (ev_d && q.size() > 0) begin
                void'(q.pop_front()); void'(qt.pop_front());
            end
            if (g >= 0) begin
                q.push_back(int'(src_data[g])); qt.push_back(g);
                m_rr = (g + 1) % N;
            end
        end
        ev_d = pcs_d && !bus_cs_data && bus_state;
        ev_s = pcs_s && !bus_cs_stat && bus_state;
        ev_f = pcs_s && !bus_cs_stat && !bus_state && bus_wdata[0];
        pcs_d = bus_cs_data;
        pcs_s = bus_cs_stat;
    endtask

    initial forever begin
        @(posedge clk or posedge reset);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            logic [N-1:0] er;
            int g;
            er = '0;
            g = grant_idx();
            if (g >= 0) er[g] = 1'b1;
            check("src_ready", src_ready, er);
            check("data_word", data_word, head());
            check("level", level, q.size());
            check("mcu_irq", mcu_irq, e_irq);
            check("stat_word", stat_word, e_stat);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic mcu_read(input bit stat, output logic [15:0] v);
        bus_state = 1;
        if (stat) bus_cs_stat = 1; else bus_cs_data = 1;
        tick(); tick();
        v = stat ? stat_word : data_word;
        if (stat) bus_cs_stat = 0; else bus_cs_data = 0;
        tick(); tick();
    endtask

    task automatic flush_write();
        bus_state = 0; bus_wdata = 16'h0001; bus_cs_stat = 1;
        tick();
        bus_cs_stat = 0;
        tick(); tick();
        bus_wdata = '0;
    endtask

    task automatic push_one(input int s, input logic [15:0] d);
        bit ok = 0;
        src_data[s] = d;
        src_valid = N'(1) << s;
        for (int t = 0; t < 50 && !ok; t++) begin
            #1;
            if (src_ready[s]) ok = 1;
            @(posedge clk); #1;
        end
        if (!ok) check("push_timeout", 0, 1);
        src_valid = '0;
    endtask

    initial begin
        logic [15:0] v;
        int n, vpct, rpct;
        bit seen8, prev8;
        for (int i = 0; i < N; i++) src_data[i] = 16'h1000 + 16'(i);
        #1 reset = 1;
        src_valid = 4'hF;
        #1 chk_on = 1;
        tick(); tick();
        check("rst_ready", src_ready, 0);
        check("rst_level", level, 0);
        check("rst_data", data_word, 0);
        check("rst_stat", stat_word, 0);
        check("rst_irq", mcu_irq, 0);
        reset = 0;
        src_valid = 4'hF;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("rr_grant", src_ready, 32'(1) << k);
            if (k > 0) check("rr_head", data_word, 16'h1000);
            tick();
        end
        src_valid = '0;
        check("rr_level", level, 4);
        check("rr_head_end", data_word, 16'h1000);

        flush_write();
        check("flush_level", level, 0);
        push_one(2, 16'hA001); push_one(2, 16'hA002); push_one(2, 16'hA003);
        tick();
        check("drain_level3", level, 3);
        mcu_read(0, v); check("drain_w1", v, 16'hA001);
        mcu_read(0, v); check("drain_w2", v, 16'hA002);
        mcu_read(0, v); check("drain_w3", v, 16'hA003);
        check("drain_level0", level, 0);
        check("drain_data0", data_word, 0);

        n = 0; seen8 = 0; prev8 = 0;
        src_valid = 4'b0100;
        for (int c = 0; c < 22; c++) begin
            src_data[2] = 16'hB000 + 16'(n);
            #1;
            if (level == 8 && !seen8) begin
                check("irq_at_8", mcu_irq, 0); seen8 = 1; prev8 = 1;
            end else if (prev8) begin
                check("irq_after_8", mcu_irq, 1); prev8 = 0;
            end
            if (src_ready[2]) n++;
            @(posedge clk); #1;
        end
        #1;
        check("full_level", level, 16);
        check("full_ready", src_ready, 0);
        check("full_count", n, 16);
        check("full_irq", mcu_irq, 1);
        src_valid = '0;
        for (int k = 0; k < 16; k++) begin
            mcu_read(0, v);
            check("full_word", v, 16'hB000 + 16'(k));
        end
        check("full_drained", level, 0);

        mcu_read(0, v);
        tick();
        check("unf_set", stat_word[15], 1);
        mcu_read(1, v);
        check("unf_stat_read", v[15], 1);
        tick();
        check("unf_cleared", stat_word[15], 0);

        for (int k = 0; k < 5; k++) push_one(1, 16'hC000 + 16'(k));
        tick();
        check("sim_level5", level, 5);
        bus_state = 1; bus_cs_data = 1;
        tick(); tick();
        bus_cs_data = 0;
        tick();
        src_data[1] = 16'hC0DE; src_valid = 4'b0010;
        tick();
        src_valid = '0;
        check("sim_pushpop", level, 5);
        check("sim_head", data_word, 16'hC001);
        src_valid = 4'b1000; bus_state = 0; bus_wdata = 16'h0001; bus_cs_stat = 1;
        tick();
        bus_cs_stat = 0;
        tick();
        #1;
        check("flush_nogrant", src_ready, 0);
        tick();
        src_valid = '0; bus_wdata = '0;
        check("flush_sim_level", level, 0);

        push_one(3, 16'h7333);
        tick();
`ifdef FSMC_ARB_SRC_TAG_EN
        check("tag_src3", stat_word[13:8], 3);
`else
        check("tag_off", stat_word[13:8], 0);
`endif
        flush_write();

        vpct = 50; rpct = 30;
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) begin
                vpct = $urandom_range(10, 90);
                rpct = $urandom_range(5, 60);
            end
            for (int i = 0; i < N; i++) begin
                src_valid[i] = $urandom_range(0, 99) < vpct;
                src_data[i] = 16'($urandom);
            end
            if ($urandom_range(0, 99) < rpct) bus_cs_data = ~bus_cs_data;
            if ($urandom_range(0, 99) < 10) bus_cs_stat = ~bus_cs_stat;
            bus_state = $urandom_range(0, 3) != 0;
            bus_wdata = {15'($urandom), $urandom_range(0, 7) == 0};
            reset = (c >= 1500 && c < 1502);
            tick();
        end
        src_valid = '0;
        tick(); tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fsmc_read_arbiter.md
# fsmc_read_arbiter

Round-robin arbiter and read FIFO that shares the FSMC read-back path among several internal data producers. Producers push words through a valid/ready handshake. The block buffers them in a FIFO and presents the head word on one FSMC chip-select slot and a status word on a second slot. It pops on each completed MCU read and raises an MCU interrupt when the fill level crosses a threshold. It sits between the producer modules and the `wr_data`/`cs`/`state`/`rd_data` side of the FSMC interface.

## Interface
- `DATA_WIDTH`, 16: word width; must be 16.
- `NUM_SOURCES`, 4: number of producers, 2..64.
- `FIFO_DEPTH`, 16: FIFO entries, power of two, 2..128.
- `IRQ_LEVEL`, 8: `mcu_irq` asserts when level >= this; 1..FIFO_DEPTH.
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `src_valid`  in  NUM_SOURCES  producer i holds a word.
- `src_data`  in  DATA_WIDTH x NUM_SOURCES  producer words, unpacked array.
- `src_ready`  out  NUM_SOURCES  one-hot grant; transfer when `src_valid[i] & src_ready[i]`.
- `bus_cs_data`  in  1  FSMC chip-select bit for the data slot.
- `bus_cs_stat`  in  1  FSMC chip-select bit for the status/control slot.
- `bus_state`  in  1  1 = MCU read, 0 = MCU write.
- `bus_wdata`  in  DATA_WIDTH  MCU write data from the FSMC interface.
- `data_word`  out  DATA_WIDTH  FIFO head, for the data-slot `wr_data`.
- `stat_word`  out  DATA_WIDTH  status, for the status-slot `wr_data`.
- `mcu_irq`  out  1  registered level interrupt.
- `level`  out  $clog2(FIFO_DEPTH)+1  current fill count.

## Operation
- **Arbitration:** combinational round-robin over `src_valid`, starting at `rr_ptr`.
  - Grant only when registered `level < FIFO_DEPTH` and no flush is occurring this cycle.
  - At most one grant per cycle.
  - After a transfer from source i, `rr_ptr` becomes (i+1) mod NUM_SOURCES. With no transfer it is unchanged.
- **Read-done event:** the `bus_cs_data` falling edge (registered previous = 1, current = 0) with `bus_state = 1`. The same rule on `bus_cs_stat` gives the status-read event.
- **Pop:** on a data read-done event.
  - Non-empty: advance the read pointer and decrement `level`.
  - Empty: set sticky `underflow`; pointers unchanged.
- **Push and pop in the same cycle:** both occur and `level` is unchanged.
- **Full:** no grant, even if a pop happens in the same cycle. Producers are back-pressured and no data is lost.
- **`data_word`:** registered head entry.
  - Equals `0x0000` when empty.
  - Updates only on push-into-empty, pop or flush, so it is stable while `bus_cs_data` is high.
- **`stat_word`:**
  - [15] `underflow`
  - [14] `mcu_irq`
  - [13:8] head source id (see Configuration)
  - [7:0] `level`, zero-extended.
- **Status read-done event:** clears `underflow`. If an underflow occurs in the same cycle, the set wins.
- **MCU write to the status slot** (`bus_cs_stat` falling edge with `bus_state = 0`) with `bus_wdata[0] = 1`: flush.
  - Pointers and `level` go to 0 and `data_word` goes to 0.
  - `rr_ptr` and `underflow` are unchanged.
  - No grant in the flush cycle; a flush overrides a simultaneous pop.
- Writes with `bus_wdata[0] = 0`, and all MCU writes to the data slot, are ignored.

## Timing
- **Reset values:**
  - `src_ready` = 0 while `reset` is high.
  - `data_word` = 0, `stat_word` = 0, `mcu_irq` = 0, `level` = 0.
  - `underflow` = 0, `rr_ptr` = 0, pointers = 0.
- **Reset mid-operation:** FIFO contents are discarded.
- **Push latency:** a transfer at edge N updates `level` at N+1. If the FIFO was empty, `data_word` shows the pushed word at N+1.
- **Pop latency:** a read-done is detected on the first clock with `bus_cs_data` low. The new head and `level` appear on the following edge, 2 clocks after `cs` falls.
- **`mcu_irq` and `stat_word`:** registered from the post-update `level`, one more cycle behind.
- **Pointer wrap:** read and write pointers wrap at FIFO_DEPTH. Full/empty is derived from `level`.

## Configuration
- **`FSMC_ARB_SRC_TAG_EN` defined:** each FIFO entry also stores the $clog2(NUM_SOURCES)-bit index of the granted source. `stat_word[13:8]` reports the head entry's index, zero-extended, or 0 when empty.
- **Not defined:** no tag storage and `stat_word[13:8]` = 0.
- Data-path behaviour is identical in both builds.

## Test plan
- **Round robin:** reset, then hold `src_valid = 4'b1111` for 4 cycles. Required: grants go 0,1,2,3 in order; `level` = 4; `data_word` equals `src_data[0]` from cycle 1.
- **Full and IRQ:** fill 16 words from source 2 with no reads. Required: `src_ready` = 0 at `level` = 16; `mcu_irq` goes high one cycle after `level` reaches 8; no word is lost.
- **Drain:** with 3 words 0xA001, 0xA002, 0xA003 queued, perform 3 MCU reads of the data slot. Required: the MCU reads them in order; `level` = 0 and `data_word` = 0x0000 afterwards.
- **Underflow:** read the data slot while empty. Required: `stat_word[15]` = 1. A subsequent status read returns bit 15 = 1 and then clears it to 0.
- **Simultaneous events:** a push on the same edge as a pop at `level` = 5 keeps `level` = 5. A flush write (`bus_wdata` = 0x0001) coinciding with `src_valid` high gives `level` = 0 and no grant that cycle.
- **Tag build:** with `FSMC_ARB_SRC_TAG_EN` defined, push from source 3. Required: `stat_word[13:8]` = 3.
